svr_stream_fifo: RTL

SVR_STREAM_FIFO -- requirements
Module: svr_stream_fifo

---
 rtl/svr_stream_fifo.sv | 78 +++++++
 1 files changed

// File: rtl/svr_stream_fifo.sv
// Synchronous stream FIFO with ready/valid handshakes on both sides,
// registered output (no fall-through), flush and almost-full indication.
module svr_stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AFULL_LVL  = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  push;
  logic                  pop;

  // Handshake status comes only from the registered occupancy, so neither
  // ready nor valid ever depends combinationally on the other side's inputs.
  always_comb begin
    s_ready     = (count_q != FULL_CNT);
    m_valid     = (count_q != '0);
    almost_full = (count_q >= AFULL_CNT);
    count       = count_q;
    m_data      = mem[rd_ptr];
    push        = s_valid && s_ready;
    pop         = m_valid && m_ready;
  end

  // Pointer and occupancy bookkeeping; reset beats flush, flush beats traffic.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage is left unreset; a write is suppressed whenever reset or flush
  // would discard the beat anyway.
  always_ff @(posedge clk) begin
    if (rst && !flush && push) begin
      mem[wr_ptr] <= s_data;
    end
  end

endmodule
